// File: rtl/array_mult_ctrl.sv
// Sequential wrapper around the combinational BIT_MULT array: registers the operands,
// waits SETTLE cycles for the ripple carries to resolve, then captures and presents the product.
module array_mult_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     arr_x,
  output logic [WIDTH-1:0]     arr_y,
  input  logic [2*WIDTH-1:0]   arr_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count,
  output logic [1:0]           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid is never withdrawn before its transfer, and ready never depends on valid.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] settle_cnt;

  assign in_ready  = (state == ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      arr_x      <= '0;
      arr_y      <= '0;
      prod       <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            arr_x <= a_in;
            arr_y <= b_in;
            busy  <= 1'b1;
            // A zero operand makes the product known without waiting on the array.
            if (a_in == '0 || b_in == '0) begin
              prod      <= '0;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              settle_cnt <= SETTLE_LOAD;
              state      <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            prod      <= arr_p;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_mult_ctrl.sv
// Bench for array_mult_ctrl: array model with settle delay, table-driven vectors,
// hand sequences for backpressure/reset/SETTLE=1 wrap, and a randomized scoreboard run.
module tb_array_mult_ctrl;

  localparam int W = 8;
  localparam int ST = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- main DUT (SETTLE=2, 16-bit counter) ----------------
  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   a_in, b_in, arr_x, arr_y;
  logic [2*W-1:0] arr_p, prod;
  logic [15:0]    op_count;
  logic [1:0]     state_dbg;

  array_mult_ctrl #(.WIDTH(W), .SETTLE(ST), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .arr_x(arr_x), .arr_y(arr_y), .arr_p(arr_p),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .busy(busy),
    .op_count(op_count), .state_dbg(state_dbg)
  );

  // Array model: output is only correct once operands have been stable long enough.
  logic [W-1:0] last_x, last_y;
  int           age;
  always @(posedge clk) begin
    if (arr_x != last_x || arr_y != last_y) age <= 1;
    else if (age < 100) age <= age + 1;
    last_x <= arr_x;
    last_y <= arr_y;
  end
  always_comb begin
    if (arr_x == last_x && arr_y == last_y && age >= ST - 1) arr_p = 16'(arr_x) * 16'(arr_y);
    else arr_p = ~(16'(arr_x) * 16'(arr_y));
  end

  // ---------------- second DUT (SETTLE=1, 4-bit counter) ----------------
  logic           iv2, ir2, ov2, or2, busy2;
  logic [W-1:0]   a2, b2, x2, y2;
  logic [2*W-1:0] p2, prod2;
  logic [3:0]     cnt2;
  logic [1:0]     st2;

  array_mult_ctrl #(.WIDTH(W), .SETTLE(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a_in(a2), .b_in(b2), .arr_x(x2), .arr_y(y2), .arr_p(p2),
    .out_valid(ov2), .out_ready(or2), .prod(prod2), .busy(busy2),
    .op_count(cnt2), .state_dbg(st2)
  );
  assign p2 = 16'(x2) * 16'(y2);

  // ---------------- checking ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    total++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  // Scoreboard: every accepted pair must come back as a*b, in order.
  logic [2*W-1:0] exp_q[$];
  int             exp_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(16'(a_in) * 16'(b_in));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_timeout("sb_unexpected_output");
        else check("sb_prod", prod, exp_q.pop_front());
        check("sb_op_count", op_count, exp_cnt);
        exp_cnt = (exp_cnt + 1) % 65536;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #2 after a rising edge with the DUT idle; returns edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    in_valid = 1'b1; a_in = a; b_in = b;
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #2;
      lat++;
    end
    if (!out_valid) fail_timeout("run_op");
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             lat;
  } vec_t;

  vec_t vecs[7];
  int   lat, ops_done, n, snap;
  logic acc;
  logic [W-1:0] ra, rb;

  initial begin
    vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'h008F, lat: 2};
    vecs[1] = '{a: 8'hFF,  b: 8'hFF,  p: 16'hFE01, lat: 2};
    vecs[2] = '{a: 8'h00,  b: 8'h5A,  p: 16'h0000, lat: 1 - 1};
    vecs[3] = '{a: 8'd1,   b: 8'hFF,  p: 16'h00FF, lat: 2};
    vecs[4] = '{a: 8'h80,  b: 8'd2,   p: 16'h0100, lat: 2};
    vecs[5] = '{a: 8'd5,   b: 8'h00,  p: 16'h0000, lat: 0};
    vecs[6] = '{a: 8'hFE,  b: 8'h81,  p: 16'h7FFE, lat: 2};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_prod", prod, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // ---- table-driven vectors ----
    out_ready = 1'b1;
    ops_done = 0;
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_prod", i), prod, vecs[i].p);
      check($sformatf("vec%0d_busy", i), busy, 1);
      @(posedge clk); #2;
      ops_done++;
      check($sformatf("vec%0d_valid_drop", i), out_valid, 0);
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      check($sformatf("vec%0d_op_count", i), op_count, ops_done);
      check($sformatf("vec%0d_prod_kept", i), prod, vecs[i].p);
    end

    // ---- backpressure, with an ignored in_valid during HOLD ----
    out_ready = 1'b0;
    run_op(8'd7, 8'd9, lat);
    check("bp_latency", lat, 2);
    in_valid = 1'b1; a_in = 8'd3; b_in = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("bp_valid_held", out_valid, 1);
      check("bp_prod_held", prod, 63);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_arr_x_held", arr_x, 7);
    end
    check("bp_count_before", op_count, ops_done);
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_count_once", op_count, ops_done + 1);
    check("bp_idle_again", in_ready, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    check("bp_next_latency", n, 2);
    check("bp_next_prod", prod, 27);
    @(posedge clk); #2;
    ops_done += 2;
    check("bp_count_after", op_count, ops_done);

    // ---- reset mid-SETTLE aborts the operation ----
    in_valid = 1'b1; a_in = 8'd13; b_in = 8'd11;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_prod", prod, 0);
    check("mid_rst_arr_x", arr_x, 0);
    check("mid_rst_arr_y", arr_y, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_op_count", op_count, 0);
      check("post_rst_prod", prod, 0);
    end

    // ---- SETTLE=1 instance: 1-edge capture and 4-bit counter wrap ----
    for (int k = 1; k <= 17; k++) begin
      a2 = 8'($urandom_range(1, 255)); b2 = 8'($urandom_range(1, 255));
      iv2 = 1'b1;
      @(posedge clk); #2;
      iv2 = 1'b0;
      check("s1_not_yet_valid", ov2, 0);
      @(posedge clk); #2;
      check("s1_valid", ov2, 1);
      check("s1_prod", prod2, 16'(a2) * 16'(b2));
      @(posedge clk); #2;
      check("s1_op_count", cnt2, k % 16);
      check("s1_idle", ir2 & ~busy2, 1);
    end
    check("s1_state_idle", st2, 0);

    // ---- randomized pairs with random backpressure ----
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) ra = '0;
      if ($urandom_range(0, 9) == 0) rb = '0;
      in_valid = 1'b1; a_in = ra; b_in = rb;
      acc = 1'b0; n = 0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #2;
        out_ready = 1'($urandom_range(0, 1));
        n++;
      end
      if (!acc) fail_timeout("rand_accept");
      in_valid = 1'b0;
      snap = $urandom_range(0, 2);
      for (int j = 0; j < snap; j++) begin
        @(posedge clk); #2;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    @(posedge clk); #2;
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_op_count", op_count, exp_cnt);
    check("rand_final_idle", in_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
